// File: rtl/ex_issue_stage.sv
// Issue register in front of the execute unit: resolves rs1/rs2 by EX/WB
// forwarding, inserts one bubble on a load-use hazard, counts decode stalls.
module ex_issue_stage #(
   parameter int XLEN     = 32,
   parameter int PARAMS_W = 6
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,

   input  logic                in_valid,
   output logic                in_ready,
   input  logic [XLEN-1:0]     in_pc,
   input  logic [XLEN-1:0]     in_imm,
   input  logic [4:0]          in_rs1_idx,
   input  logic [4:0]          in_rs2_idx,
   input  logic [4:0]          in_rd,
   input  logic [XLEN-1:0]     in_rs1_val,
   input  logic [XLEN-1:0]     in_rs2_val,
   input  logic [PARAMS_W-1:0] in_params,
   input  logic                in_is_load,

   output logic                out_valid,
   input  logic                out_ready,
   output logic [XLEN-1:0]     out_pc,
   output logic [XLEN-1:0]     out_rs1,
   output logic [XLEN-1:0]     out_rs2,
   output logic [XLEN-1:0]     out_imm,
   output logic [PARAMS_W-1:0] out_params,
   output logic [4:0]          out_rd,
   output logic                out_is_load,

   input  logic [XLEN-1:0]     exec_result,
   input  logic                wb_valid,
   input  logic [4:0]          wb_rd,
   input  logic [XLEN-1:0]     wb_data,

   output logic [31:0]         stall_count
);

   logic            free;
   logic            hz;
   logic            capture;
   logic [XLEN-1:0] rs1_fwd;
   logic [XLEN-1:0] rs2_fwd;
   logic [31:0]     stall_cnt_q;

   // EX result is the younger producer, so it outranks writeback. A load in
   // EX only has an address, never the loaded data, so it is not forwarded.
   function automatic logic [XLEN-1:0] resolve(
      input logic [4:0]      idx,
      input logic [XLEN-1:0] rf_val,
      input logic            ex_hit_ok,
      input logic [4:0]      ex_rd,
      input logic [XLEN-1:0] ex_val,
      input logic            wb_ok,
      input logic [4:0]      wb_idx,
      input logic [XLEN-1:0] wb_val
   );
      if (idx == 5'd0)
         return rf_val;
      else if (ex_hit_ok && ex_rd == idx)
         return ex_val;
      else if (wb_ok && wb_idx == idx)
         return wb_val;
      else
         return rf_val;
   endfunction

   always_comb begin
      free     = !out_valid || out_ready;
      hz       = out_valid && out_is_load && (out_rd != 5'd0) &&
                 ((out_rd == in_rs1_idx) || (out_rd == in_rs2_idx));
      in_ready = free && !hz && !flush;
      capture  = in_valid && in_ready;
      rs1_fwd  = resolve(in_rs1_idx, in_rs1_val, out_valid && !out_is_load,
                         out_rd, exec_result, wb_valid, wb_rd, wb_data);
      rs2_fwd  = resolve(in_rs2_idx, in_rs2_val, out_valid && !out_is_load,
                         out_rd, exec_result, wb_valid, wb_rd, wb_data);
   end

   // NOTE: registered state uses non-blocking assignments so every flop in
   // this block samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid   <= 1'b0;
         out_pc      <= '0;
         out_rs1     <= '0;
         out_rs2     <= '0;
         out_imm     <= '0;
         out_params  <= '0;
         out_rd      <= '0;
         out_is_load <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         if (flush) begin
            out_valid <= 1'b0;
         end else if (capture) begin
            out_valid   <= 1'b1;
            out_pc      <= in_pc;
            out_rs1     <= rs1_fwd;
            out_rs2     <= rs2_fwd;
            out_imm     <= in_imm;
            out_params  <= in_params;
            out_rd      <= in_rd;
            out_is_load <= in_is_load;
         end else if (free) begin
            out_valid <= 1'b0;
         end

         // A flushed offer is discarded, not stalled, so it is not counted.
         if (in_valid && !in_ready && !flush)
            stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_ex_issue_stage.sv
// Self-checking bench for ex_issue_stage: forwarding vector table plus
// hand-written load-use, back-pressure, flush, wrap and reset sequences.
module tb_ex_issue_stage;

   localparam int XLEN     = 32;
   localparam int PARAMS_W = 6;

   logic                clk;
   logic                rst;
   logic                flush;
   logic                in_valid;
   logic                in_ready;
   logic [XLEN-1:0]     in_pc;
   logic [XLEN-1:0]     in_imm;
   logic [4:0]          in_rs1_idx;
   logic [4:0]          in_rs2_idx;
   logic [4:0]          in_rd;
   logic [XLEN-1:0]     in_rs1_val;
   logic [XLEN-1:0]     in_rs2_val;
   logic [PARAMS_W-1:0] in_params;
   logic                in_is_load;
   logic                out_valid;
   logic                out_ready;
   logic [XLEN-1:0]     out_pc;
   logic [XLEN-1:0]     out_rs1;
   logic [XLEN-1:0]     out_rs2;
   logic [XLEN-1:0]     out_imm;
   logic [PARAMS_W-1:0] out_params;
   logic [4:0]          out_rd;
   logic                out_is_load;
   logic [XLEN-1:0]     exec_result;
   logic                wb_valid;
   logic [4:0]          wb_rd;
   logic [XLEN-1:0]     wb_data;
   logic [31:0]         stall_count;

   ex_issue_stage #(.XLEN(XLEN), .PARAMS_W(PARAMS_W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_imm(in_imm),
      .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx), .in_rd(in_rd),
      .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
      .in_params(in_params), .in_is_load(in_is_load),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
      .out_params(out_params), .out_rd(out_rd), .out_is_load(out_is_load),
      .exec_result(exec_result),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .stall_count(stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc, imm;
      logic [4:0]  rs1_idx, rs2_idx, rd;
      logic [31:0] rs1_val, rs2_val;
      logic [5:0]  params;
      logic [31:0] exec_res;
      logic        wbv;
      logic [4:0]  wbrd;
      logic [31:0] wbd;
      logic [31:0] exp_rs1, exp_rs2;
   } vec_t;

   typedef struct {
      logic [31:0] pc, imm, rs1, rs2;
      logic [5:0]  params;
      logic [4:0]  rd;
      logic        is_load;
   } exp_t;

   int   checks = 0;
   int   errors = 0;
   exp_t sb_q[$];
   exp_t cur_exp;
   exp_t last_exp;
   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
      end
   endtask

   function automatic vec_t mk(
      input logic [31:0] pc, input logic [31:0] imm,
      input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
      input logic [31:0] v1, input logic [31:0] v2, input logic [5:0] prm,
      input logic [31:0] ex, input logic wbv, input logic [4:0] wbrd,
      input logic [31:0] wbd, input logic [31:0] e1, input logic [31:0] e2);
      vec_t v;
      v.pc = pc; v.imm = imm; v.rs1_idx = r1; v.rs2_idx = r2; v.rd = rd;
      v.rs1_val = v1; v.rs2_val = v2; v.params = prm; v.exec_res = ex;
      v.wbv = wbv; v.wbrd = wbrd; v.wbd = wbd; v.exp_rs1 = e1; v.exp_rs2 = e2;
      return v;
   endfunction

   task automatic drive(input logic [31:0] pc, input logic [31:0] imm,
                        input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                        input logic [31:0] v1, input logic [31:0] v2,
                        input logic [5:0] prm, input logic ld);
      in_valid = 1'b1; in_pc = pc; in_imm = imm;
      in_rs1_idx = r1; in_rs2_idx = r2; in_rd = rd;
      in_rs1_val = v1; in_rs2_val = v2; in_params = prm; in_is_load = ld;
      cur_exp.pc = pc; cur_exp.imm = imm; cur_exp.params = prm;
      cur_exp.rd = rd; cur_exp.is_load = ld;
   endtask

   // One clock: check the combinational handshake, push the expected capture,
   // then after the edge compare against the scoreboard or the held record.
   task automatic cycle(input logic exp_rdy, input logic exp_v, input logic [31:0] exp_sc);
      exp_t e;
      #1;
      check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      if (exp_rdy && in_valid) sb_q.push_back(cur_exp);
      @(posedge clk);
      #1;
      check("out_valid", {31'd0, out_valid}, {31'd0, exp_v});
      check("stall_count", stall_count, exp_sc);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check("cap_pc", out_pc, e.pc);
         check("cap_imm", out_imm, e.imm);
         check("cap_rs1", out_rs1, e.rs1);
         check("cap_rs2", out_rs2, e.rs2);
         check("cap_params", {26'd0, out_params}, {26'd0, e.params});
         check("cap_rd", {27'd0, out_rd}, {27'd0, e.rd});
         check("cap_is_load", {31'd0, out_is_load}, {31'd0, e.is_load});
         last_exp = e;
      end else if (exp_v) begin
         check("hold_pc", out_pc, last_exp.pc);
         check("hold_rs1", out_rs1, last_exp.rs1);
         check("hold_rs2", out_rs2, last_exp.rs2);
         check("hold_rd", {27'd0, out_rd}, {27'd0, last_exp.rd});
      end
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_pc = '0; in_imm = '0; in_rs1_idx = '0; in_rs2_idx = '0; in_rd = '0;
      in_rs1_val = '0; in_rs2_val = '0; in_params = '0; in_is_load = 1'b0;
      exec_result = '0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
      cur_exp = '{default: '0};
      last_exp = '{default: '0};

      // Table: exec_result belongs to the previous row's instruction (in EX).
      vecs[0] = mk(32'h100, 32'd5, 5'd0, 5'd0, 5'd1, 32'h0, 32'h0, 6'h11,
                   32'h0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
      vecs[1] = mk(32'h104, 32'd0, 5'd1, 5'd1, 5'd2, 32'hAAAA, 32'hAAAA, 6'h02,
                   32'd5, 1'b0, 5'd0, 32'h0, 32'd5, 32'd5);
      vecs[2] = mk(32'h108, 32'd0, 5'd2, 5'd1, 5'd3, 32'h11, 32'h22, 6'h03,
                   32'd10, 1'b1, 5'd1, 32'd5, 32'd10, 32'd5);
      vecs[3] = mk(32'h10C, 32'd7, 5'd3, 5'd3, 5'd3, 32'h33, 32'h33, 6'h04,
                   32'h77, 1'b1, 5'd3, 32'h99, 32'h77, 32'h77);
      vecs[4] = mk(32'h110, 32'd0, 5'd0, 5'd5, 5'd0, 32'h0, 32'h5555, 6'h05,
                   32'h1234, 1'b1, 5'd0, 32'h55, 32'h0, 32'h5555);
      vecs[5] = mk(32'h114, 32'd0, 5'd0, 5'd0, 5'd4, 32'h0, 32'h0, 6'h06,
                   32'h1234, 1'b1, 5'd0, 32'h55, 32'h0, 32'h0);
      vecs[6] = mk(32'h118, 32'd0, 5'd6, 5'd7, 5'd8, 32'h66, 32'h77, 6'h07,
                   32'hCAFE, 1'b0, 5'd6, 32'hBAD, 32'h66, 32'h77);
      vecs[7] = mk(32'h11C, 32'd0, 5'd8, 5'd4, 5'd9, 32'h88, 32'h44444, 6'h08,
                   32'hE8, 1'b1, 5'd4, 32'h44, 32'hE8, 32'h44);

      @(posedge clk); #1;
      @(posedge clk); #1;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_pc", out_pc, 32'd0);
      check("rst_out_rs1", out_rs1, 32'd0);
      check("rst_stall_count", stall_count, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         drive(vecs[i].pc, vecs[i].imm, vecs[i].rs1_idx, vecs[i].rs2_idx, vecs[i].rd,
               vecs[i].rs1_val, vecs[i].rs2_val, vecs[i].params, 1'b0);
         exec_result = vecs[i].exec_res;
         wb_valid = vecs[i].wbv; wb_rd = vecs[i].wbrd; wb_data = vecs[i].wbd;
         cur_exp.rs1 = vecs[i].exp_rs1; cur_exp.rs2 = vecs[i].exp_rs2;
         cycle(1'b1, 1'b1, 32'd0);
      end

      // Idle cycle drains the slot.
      in_valid = 1'b0; wb_valid = 1'b0;
      cycle(1'b1, 1'b0, 32'd0);

      // Load-use: load x3, dependent stalls one cycle, then takes WB data.
      drive(32'h200, 32'h40, 5'd0, 5'd0, 5'd3, 32'h0, 32'h0, 6'h01, 1'b1);
      cur_exp.rs1 = 32'h0; cur_exp.rs2 = 32'h0;
      cycle(1'b1, 1'b1, 32'd0);
      drive(32'h204, 32'h0, 5'd3, 5'd0, 5'd5, 32'hAAAA0000, 32'h0, 6'h2A, 1'b0);
      exec_result = 32'h2040;
      cycle(1'b0, 1'b0, 32'd1);
      wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEADBEEF;
      cur_exp.rs1 = 32'hDEADBEEF; cur_exp.rs2 = 32'h0;
      cycle(1'b1, 1'b1, 32'd1);

      // Back-pressure for 4 cycles, then release.
      wb_valid = 1'b0; exec_result = 32'h5555;
      drive(32'h208, 32'h8, 5'd1, 5'd2, 5'd6, 32'h101, 32'h202, 6'h0C, 1'b0);
      cur_exp.rs1 = 32'h101; cur_exp.rs2 = 32'h202;
      out_ready = 1'b0;
      for (int k = 1; k <= 4; k++) cycle(1'b0, 1'b1, 32'd1 + 32'(k));
      out_ready = 1'b1;
      cycle(1'b1, 1'b1, 32'd5);

      // Flush while held: slot empties, offer dropped, stall not counted.
      out_ready = 1'b0; flush = 1'b1;
      drive(32'h20C, 32'h0, 5'd0, 5'd0, 5'd7, 32'h0, 32'h0, 6'h0D, 1'b0);
      cycle(1'b0, 1'b0, 32'd5);
      check("flush_hold_pc", out_pc, 32'h208);
      check("flush_hold_rd", {27'd0, out_rd}, 32'd6);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      cycle(1'b1, 1'b0, 32'd5);

      // Counter wrap via backdoor preload, then reset mid-stall.
      drive(32'h300, 32'h0, 5'd0, 5'd0, 5'd9, 32'h0, 32'h0, 6'h0E, 1'b0);
      cur_exp.rs1 = 32'h0; cur_exp.rs2 = 32'h0;
      cycle(1'b1, 1'b1, 32'd5);
      force dut.stall_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.stall_cnt_q;
      check("preload_stall_count", stall_count, 32'hFFFF_FFFF);
      out_ready = 1'b0;
      drive(32'h304, 32'h0, 5'd0, 5'd0, 5'd10, 32'h0, 32'h0, 6'h0F, 1'b0);
      cycle(1'b0, 1'b1, 32'd0);
      cycle(1'b0, 1'b1, 32'd1);
      rst = 1'b1;
      cycle(1'b0, 1'b0, 32'd0);
      check("midrst_out_pc", out_pc, 32'd0);
      check("midrst_out_rd", {27'd0, out_rd}, 32'd0);
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      check("sb_empty", sb_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ex_issue_stage.md
# ex_issue_stage

Pipeline register and operand-resolution stage directly upstream of the execute unit. Accepts decoded instructions from decode over a valid/ready handshake and resolves rs1/rs2 by forwarding from the instruction currently in execute and from writeback. Detects load-use hazards and inserts a single bubble. Presents registered, stable operands and `exec_unit_params` to the execute unit.

## Interface
- `XLEN`, 32: data/PC width.
- `PARAMS_W`, 6: width of `exec_unit_params` (op1_sel 1 + op2_sel 1 + exec_op 4).
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `flush` input 1: branch/trap redirect; discards the held and incoming instruction.
- `in_valid` input 1: decode offers an instruction.
- `in_ready` output 1: stage accepts this cycle.
- `in_pc`, `in_imm` input XLEN: PC and immediate.
- `in_rs1_idx`, `in_rs2_idx`, `in_rd` input 5: register indices.
- `in_rs1_val`, `in_rs2_val` input XLEN: register file read data. Does not reflect a same-cycle write.
- `in_params` input PARAMS_W: execute controls.
- `in_is_load` input 1: instruction is a load; its execute result is an address.
- `out_valid` output 1: execute slot holds a valid instruction.
- `out_ready` input 1: execute/downstream accepts this cycle.
- `out_pc`, `out_rs1`, `out_rs2`, `out_imm` output XLEN: registered operands to the execute unit.
- `out_params` output PARAMS_W; `out_rd` output 5; `out_is_load` output 1.
- `exec_result` input XLEN: execute unit output for the current `out_*` contents.
- `wb_valid` input 1, `wb_rd` input 5, `wb_data` input XLEN: writeback port, identical to the register file write port.
- `stall_count` output 32: cycles in which decode was back-pressured.

## Operation
- Slot free: `free = !out_valid || out_ready`.
- Load-use hazard: `hz = out_valid && out_is_load && out_rd != 0 && (out_rd == in_rs1_idx || out_rd == in_rs2_idx)`. Both sources are compared unconditionally.
- `in_ready = free && !hz && !flush`. Purely combinational.
- Operand select for each source (rsN), highest priority first:
  - EX forward: `exec_result` when `out_valid && !out_is_load && out_rd == idx && idx != 0`.
  - WB forward: `wb_data` when `wb_valid && wb_rd == idx && idx != 0`.
  - Otherwise: `in_rsN_val`.
  - Index 0 always yields `in_rsN_val`, which the register file drives as 0.
- Register update, in priority order:
  - `rst`: `out_valid=0`, all `out_*` data=0, `stall_count=0`.
  - `flush`: `out_valid=0`; data fields hold their value; nothing is captured.
  - `in_valid && in_ready`: capture pc, imm, params, rd, is_load and the forwarded rs1/rs2; `out_valid=1`.
  - `free` and no capture: `out_valid=0`. This is a bubble, including the load-use bubble.
  - Otherwise (`out_valid && !out_ready`): hold all outputs unchanged.
- Load-use resolution: the cycle the load leaves, one bubble is inserted. The next cycle the load is in writeback, so the dependent instruction captures `wb_data` via WB forwarding.
- `stall_count` increments on every cycle with `in_valid && !in_ready && !flush && !rst`. It is 32-bit and wraps from 0xFFFFFFFF to 0.
- Data fields (`out_pc` … `out_is_load`) change only on capture or reset. With `out_valid=0` their values are don't-care to consumers.

## Timing
- Latency: 1 cycle from accepted `in_valid && in_ready` to `out_valid=1` with the captured data.
- Throughput: 1 instruction/cycle while `out_ready=1` and no hazard.
- Load-use costs exactly 1 bubble cycle.
- Back-pressure: while `out_valid && !out_ready`, all `out_*` are stable and `in_ready=0`.
- `flush` asserted in the same cycle as `in_valid`: the instruction is dropped, `in_ready=0`, and the stall is not counted.
- `flush` during `out_valid && !out_ready`: `out_valid=0` next cycle, regardless of `out_ready`.
- Reset mid-stream: next cycle `out_valid=0` and `stall_count=0`; any in-flight instruction is discarded.
- Simultaneous EX and WB match on the same index: EX wins (it is the younger producer).

## Test plan
- Back-to-back ALU chain: `addi x1,x0,5` then `add x2,x1,x1` with `exec_result=5` → second instruction captured with `out_rs1=out_rs2=5`, no bubble, `stall_count=0`.
- Load-use: load `x3` in EX, next instruction reads `x3` → `in_ready=0` for 1 cycle and `out_valid=0` for 1 cycle. Then capture with `wb_rd=3`, `wb_data=0xDEADBEEF` gives `out_rs1=0xDEADBEEF`; `stall_count=1`.
- x0 guard: `out_rd=0`, `exec_result=0x1234`, `wb_rd=0`, `wb_data=0x55`, consumer reads x0 with `in_rs1_val=0` → `out_rs1=0`.
- Back-pressure: hold `out_ready=0` for 4 cycles with `in_valid=1` → `out_*` unchanged, `in_ready=0`, `stall_count` +4. Release → next instruction is captured the following cycle.
- Flush: `flush=1` while `out_valid=1`, `out_ready=0`, `in_valid=1` → next cycle `out_valid=0`, the incoming instruction is not captured, `stall_count` unchanged.
- Counter wrap and reset: preload `stall_count` by forcing 0xFFFFFFFF stall cycles (or a backdoor), stall 1 cycle → reads 0. Assert `rst` mid-stall → `out_valid=0` and `stall_count=0` the next cycle.
